decode_3x8_stream: RTL and testbench

DECODE_3X8_STREAM -- requirements
Module: decode_3x8_stream

---
 rtl/decode_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/decode_3x8_stream.sv | 91 +++++++++
 tb/tb_decode_3x8_stream.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the buffered 3-to-8 decoder:
//   W_CODE_DEF  default binary code width
//   W_ONEHOT    one-hot width for the default code width (2**W_CODE_DEF)
//   bin2onehot  binary index -> one-hot vector (code 3'b111 -> bit 7)
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int W_CODE_DEF = 3;
    localparam int W_ONEHOT   = 2 ** W_CODE_DEF;

    // Sets exactly the bit selected by the binary code.
    function automatic logic [W_ONEHOT-1:0] bin2onehot(input logic [W_CODE_DEF-1:0] code);
        logic [W_ONEHOT-1:0] v;
        v = {{(W_ONEHOT-1){1'b0}}, 1'b1} << code;
        return v;
    endfunction

endpackage : decode_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears pointers and level)
//   push   write wdata at the write pointer (ignored when full)
//   pop    advance the read pointer (ignored when empty)
//   wdata  WIDTH-bit write data
//   rdata  WIDTH-bit data at the read pointer (combinational read)
//   level  number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    // Qualify requests so an overflow or underflow can never corrupt state.
    always_comb begin
        w_full  = (r_level == LW'(DEPTH));
        w_empty = (r_level == {LW{1'b0}});
        w_wr    = push && !w_full;
        w_rd    = pop && !w_empty;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {LW{1'b0}};
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Read port and level output.
    always_comb begin
        rdata = r_mem[r_rptr];
        level = r_level;
    end

endmodule : sync_fifo

// File: rtl/decode_3x8_stream.sv
// -----------------------------------------------------------------------------
// decode_3x8_stream
// Buffers binary codes in a FIFO and presents the head code decoded to
// one-hot, with valid/ready handshakes on both sides and an output enable.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             1 = drain buffer to the output, 0 = output held off
//   in_valid/ready upstream handshake; in_ready = (level < DEPTH)
//   in_code        W_CODE-bit binary code to buffer
//   out_valid      en && buffer not empty
//   out_ready      downstream accepts the head this cycle
//   out_onehot     one-hot decode of the head (zero when out_valid = 0)
//   out_code       binary head code (zero when empty)
//   level          number of buffered codes
// -----------------------------------------------------------------------------
module decode_3x8_stream
    import decode_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int W_CODE = W_CODE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W_CODE-1:0]        in_code,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(2**W_CODE)-1:0]   out_onehot,
    output logic [W_CODE-1:0]        out_code,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int W_OH = 2 ** W_CODE;

    logic [W_CODE-1:0] w_rdata;
    logic [LW-1:0]     w_level;
    logic [W_OH-1:0]   w_dec;
    logic              w_not_empty;
    logic              w_push;
    logic              w_pop;

    // Handshake qualification. in_ready looks only at the registered level,
    // so a pop in the same cycle never opens a slot for a push while full.
    always_comb begin
        w_not_empty = (w_level != {LW{1'b0}});
        in_ready    = (w_level < LW'(DEPTH));
        out_valid   = en && w_not_empty;
        w_push      = in_valid && in_ready;
        w_pop       = out_valid && out_ready;
    end

    sync_fifo #(
        .WIDTH (W_CODE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_code),
        .rdata (w_rdata),
        .level (w_level)
    );

    // Decode after the FIFO read port; the shared function covers the
    // default code width, other widths use an equivalent shift.
    if (W_CODE == W_CODE_DEF) begin : g_pkg_dec
        assign w_dec = bin2onehot(w_rdata);
    end else begin : g_gen_dec
        assign w_dec = {{(W_OH-1){1'b0}}, 1'b1} << w_rdata;
    end

    // Output gating: raw storage contents never leak when empty or disabled.
    always_comb begin
        level = w_level;
        if (out_valid) begin
            out_onehot = w_dec;
        end else begin
            out_onehot = {W_OH{1'b0}};
        end
        if (w_not_empty) begin
            out_code = w_rdata;
        end else begin
            out_code = {W_CODE{1'b0}};
        end
    end

endmodule : decode_3x8_stream

// File: tb/tb_decode_3x8_stream.sv
module tb_decode_3x8_stream;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_code = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_onehot;
    logic [2:0] out_code;
    logic [2:0] level;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the buffered codes, head at index 0.
    int mq[$];

    always #5 clk = ~clk;

    decode_3x8_stream #(.DEPTH(DEPTH), .W_CODE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .level      (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every output against what the queue model says right now.
    task automatic compare_all();
        int          sz;
        logic        e_valid;
        logic [7:0]  e_oh;
        logic [2:0]  e_code;
        sz      = mq.size();
        e_valid = en && (sz > 0);
        e_code  = (sz > 0) ? 3'(mq[0]) : 3'd0;
        e_oh    = e_valid ? 8'(1 << mq[0]) : 8'd0;
        check("in_ready",   32'(in_ready),   32'(sz < DEPTH));
        check("out_valid",  32'(out_valid),  32'(e_valid));
        check("out_onehot", 32'(out_onehot), 32'(e_oh));
        check("out_code",   32'(out_code),   32'(e_code));
        check("level",      32'(level),      32'(sz));
        if (out_valid === 1'b1) begin
            check("onehot_popcount", 32'($countones(out_onehot)), 32'd1);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic cyc(input logic v, input int c, input logic r, input logic e,
                       input logic rn, input bit chk);
        bit acc;
        bit pop;
        in_valid  = v;
        in_code   = 3'(c);
        out_ready = r;
        en        = e;
        rst_n     = rn;
        #1;
        if (chk) compare_all();
        acc = v && (mq.size() < DEPTH);
        pop = e && (mq.size() > 0) && r;
        @(posedge clk);
        if (!rn) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(c & 7);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset: first cycle unchecked (state unknown), then reset state.
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Single push of 111, visible the next cycle, then popped.
        cyc(1'b1, 7, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Fill to full with out_ready=0; fifth push rejected; drain in order.
        cyc(1'b1, 6, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b1);   // full + pop: push still refused
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // en=0: pushes buffered, output off; then drain with en=1.
        cyc(1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Level 2, then continuous push+pop across pointer wrap.
        cyc(1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, (i + 2) % 8, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Three buffered codes, reset for one cycle with a push offered.
        cyc(1'b1, 5, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Every code pushed singly.
        for (int c = 0; c < 8; c++) begin
            cyc(1'b1, c, 1'b1, 1'b1, 1'b1, 1'b1);
            cyc(1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 63) != 0), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_decode_3x8_stream
